// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac
//   Fractional-N baud-rate tick generator for a UART. A down-counter
//   reloads with baud_val every period; a FRAC_W-bit accumulator adds the
//   latched fraction on each period end and, on carry, stretches that
//   period by one clock. This gives a long-run tick interval of
//   baud_val + 1 + baud_frac / 2**FRAC_W clocks. An oversample phase
//   counter divides the ticks down to a one-per-bit transmit pulse.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   enable      count enable; low freezes all state
//   restart     synchronous restart strobe; overrides enable
//   baud_val    integer divisor minus one
//   baud_frac   fractional divisor, units of 1/2**FRAC_W
//   baud_tick   registered one-cycle oversample tick
//   xmit_pulse  registered one-cycle bit pulse (every OVERSAMPLE-th tick)
//   os_cnt      current oversample phase, 0..OVERSAMPLE-1

module uart_baud_gen_frac #(
    parameter int unsigned CNTR_W     = 13,
    parameter int unsigned FRAC_W     = 3,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic                            restart,
    input  logic [CNTR_W-1:0]               baud_val,
    input  logic [FRAC_W-1:0]               baud_frac,
    output logic                            baud_tick,
    output logic                            xmit_pulse,
    output logic [$clog2(OVERSAMPLE)-1:0]   os_cnt
);

    localparam int unsigned OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    // Registered state
    logic [CNTR_W-1:0] cntr;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] frac_q;
    logic              stretch;

    // Next-state values
    logic [CNTR_W-1:0] cntr_d;
    logic [FRAC_W-1:0] acc_d;
    logic [FRAC_W-1:0] frac_d;
    logic              stretch_d;
    logic [OS_W-1:0]   os_d;
    logic              tick_d;
    logic              xmit_d;

    // Accumulator sum with carry in the top bit
    logic [FRAC_W:0]   sum;

    always_comb begin
        sum       = {1'b0, acc} + {1'b0, frac_q};

        cntr_d    = cntr;
        acc_d     = acc;
        frac_d    = frac_q;
        stretch_d = stretch;
        os_d      = os_cnt;
        tick_d    = 1'b0;
        xmit_d    = 1'b0;

        if (restart) begin
            // Counter starts at zero so the first enabled edge reloads
            // immediately; accumulator is cleared so that reload sees no carry.
            cntr_d    = '0;
            acc_d     = '0;
            frac_d    = baud_frac;
            stretch_d = 1'b0;
            os_d      = '0;
        end else if (enable) begin
            if (cntr != '0) begin
                cntr_d = cntr - 1'b1;
            end else if (!stretch && sum[FRAC_W]) begin
                // Carry: hold the counter at zero for one extra clock.
                acc_d     = sum[FRAC_W-1:0];
                stretch_d = 1'b1;
            end else begin
                // Reload. The accumulator was already advanced on the
                // stretch cycle, so only update it on a carry-free period.
                if (!stretch) begin
                    acc_d = sum[FRAC_W-1:0];
                end
                cntr_d    = baud_val;
                frac_d    = baud_frac;
                stretch_d = 1'b0;
                tick_d    = 1'b1;
                xmit_d    = (os_cnt == OS_LAST);
                os_d      = os_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cntr       <= '0;
            acc        <= '0;
            frac_q     <= '0;
            stretch    <= 1'b0;
            os_cnt     <= '0;
            baud_tick  <= 1'b0;
            xmit_pulse <= 1'b0;
        end else begin
            cntr       <= cntr_d;
            acc        <= acc_d;
            frac_q     <= frac_d;
            stretch    <= stretch_d;
            os_cnt     <= os_d;
            baud_tick  <= tick_d;
            xmit_pulse <= xmit_d;
        end
    end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb_uart_baud_gen_frac
//   Directed self-checking bench for uart_baud_gen_frac with the default
//   parameters (CNTR_W=13, FRAC_W=3, OVERSAMPLE=16). Inputs change and
//   outputs are sampled 1 ns after each rising clock edge.

module tb_uart_baud_gen_frac;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        restart;
    logic [12:0] baud_val;
    logic [2:0]  baud_frac;
    logic        baud_tick;
    logic        xmit_pulse;
    logic [3:0]  os_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_baud_gen_frac #(
        .CNTR_W     (13),
        .FRAC_W     (3),
        .OVERSAMPLE (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .restart    (restart),
        .baud_val   (baud_val),
        .baud_frac  (baud_frac),
        .baud_tick  (baud_tick),
        .xmit_pulse (xmit_pulse),
        .os_cnt     (os_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with the given divisor, then release with enable high so the
    // next step() is the first enabled edge.
    task automatic do_reset(input logic [12:0] bv, input logic [2:0] bf);
        enable    = 1'b0;
        restart   = 1'b0;
        baud_val  = bv;
        baud_frac = bf;
        reset_n   = 1'b0;
        repeat (2) step();
        reset_n   = 1'b1;
        enable    = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        enable    = 1'b1;
        restart   = 1'b0;
        baud_val  = 13'd0;
        baud_frac = 3'd0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (baud_tick !== 1'b0 || xmit_pulse !== 1'b0 || os_cnt !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: tick=%b xmit=%b os=%0d required 0/0/0",
                         c, baud_tick, xmit_pulse, os_cnt);
            end
        end
    endtask

    task automatic test_integer_rate();
        logic       exp_tick;
        logic       exp_x;
        logic [3:0] exp_os;
        int         n;
        do_reset(13'd3, 3'd0);
        for (int c = 1; c <= 130; c++) begin
            step();
            exp_tick = ((c - 1) % 4 == 0);
            n        = (c - 1) / 4 + 1;
            exp_os   = 4'(n % 16);
            exp_x    = exp_tick && (n % 16 == 0);
            n_checks++;
            if (baud_tick !== exp_tick) begin
                n_fail++;
                $display("FAIL int_rate_tick[c=%0d]: got %b required %b", c, baud_tick, exp_tick);
            end
            n_checks++;
            if (xmit_pulse !== exp_x) begin
                n_fail++;
                $display("FAIL int_rate_xmit[c=%0d]: got %b required %b", c, xmit_pulse, exp_x);
            end
            n_checks++;
            if (os_cnt !== exp_os) begin
                n_fail++;
                $display("FAIL int_rate_os[c=%0d]: got %0d required %0d", c, os_cnt, exp_os);
            end
        end
    endtask

    // Collect the first nticks tick cycles after reset and compare the
    // intervals and the total span against hand-computed values.
    task automatic check_intervals(input string name, input int nticks,
                                   input int exp_iv[8], input int exp_total);
        int ticks[$];
        for (int c = 1; c <= 200 && ticks.size() < nticks; c++) begin
            step();
            if (baud_tick === 1'b1) ticks.push_back(c);
        end
        n_checks++;
        if (ticks.size() != nticks) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d ticks required %0d", name, ticks.size(), nticks);
        end else begin
            n_checks++;
            if (ticks[0] != 1) begin
                n_fail++;
                $display("FAIL %s_first: got cycle %0d required 1", name, ticks[0]);
            end
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (ticks[i+1] - ticks[i] != exp_iv[i]) begin
                    n_fail++;
                    $display("FAIL %s_iv[%0d]: got %0d required %0d",
                             name, i, ticks[i+1] - ticks[i], exp_iv[i]);
                end
            end
            n_checks++;
            if (ticks[8] - ticks[0] != exp_total) begin
                n_fail++;
                $display("FAIL %s_total: got %0d required %0d",
                         name, ticks[8] - ticks[0], exp_total);
            end
        end
    endtask

    task automatic test_half_fraction();
        int iv[8] = '{4, 5, 4, 5, 4, 5, 4, 5};
        do_reset(13'd3, 3'd4);
        check_intervals("half_frac", 9, iv, 36);
    endtask

    task automatic test_min_divisor();
        int iv[8] = '{1, 2, 2, 2, 2, 2, 2, 2};
        do_reset(13'd0, 3'd7);
        check_intervals("min_div", 9, iv, 15);
    endtask

    task automatic test_freeze();
        logic exp_tick;
        do_reset(13'd3, 3'd0);
        step();
        n_checks++;
        if (baud_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL freeze_first_tick: got %b required 1", baud_tick);
        end
        step();             // cntr now 2
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++;
            if (baud_tick !== 1'b0 || os_cnt !== 4'd1) begin
                n_fail++;
                $display("FAIL freeze_hold[%0d]: tick=%b os=%0d required 0/1", c, baud_tick, os_cnt);
            end
        end
        enable = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            exp_tick = (c == 3);
            n_checks++;
            if (baud_tick !== exp_tick) begin
                n_fail++;
                $display("FAIL freeze_resume[%0d]: got %b required %b", c, baud_tick, exp_tick);
            end
        end
        n_checks++;
        if (os_cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL freeze_os_after: got %0d required 2", os_cnt);
        end
    endtask

    task automatic test_mid_period_change();
        logic exp_tick;
        do_reset(13'd3, 3'd0);
        repeat (3) step();  // tick on edge 1, cntr now 1
        baud_val = 13'd7;
        for (int k = 4; k <= 14; k++) begin
            step();
            exp_tick = (k == 5 || k == 13);
            n_checks++;
            if (baud_tick !== exp_tick) begin
                n_fail++;
                $display("FAIL mid_change_tick[edge=%0d]: got %b required %b", k, baud_tick, exp_tick);
            end
        end
        // Restart with enable low; also latches a new fraction.
        restart   = 1'b1;
        enable    = 1'b0;
        baud_val  = 13'd3;
        baud_frac = 3'd4;
        step();
        n_checks++;
        if (baud_tick !== 1'b0 || xmit_pulse !== 1'b0 || os_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL restart_state: tick=%b xmit=%b os=%0d required 0/0/0",
                     baud_tick, xmit_pulse, os_cnt);
        end
        restart = 1'b0;
        enable  = 1'b1;
        // Relative to the restart edge (15): ticks at 16, 21, 25.
        for (int k = 16; k <= 25; k++) begin
            step();
            exp_tick = (k == 16 || k == 21 || k == 25);
            n_checks++;
            if (baud_tick !== exp_tick) begin
                n_fail++;
                $display("FAIL restart_tick[edge=%0d]: got %b required %b", k, baud_tick, exp_tick);
            end
            if (k == 16) begin
                n_checks++;
                if (os_cnt !== 4'd1) begin
                    n_fail++;
                    $display("FAIL restart_os_first: got %0d required 1", os_cnt);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic       exp_x;
        logic [3:0] exp_os;
        do_reset(13'd0, 3'd0);
        for (int c = 1; c <= 40; c++) begin
            step();
            exp_x  = (c % 16 == 0);
            exp_os = 4'(c % 16);
            n_checks++;
            if (baud_tick !== 1'b1 || xmit_pulse !== exp_x || os_cnt !== exp_os) begin
                n_fail++;
                $display("FAIL b2b[c=%0d]: tick=%b xmit=%b os=%0d required 1/%b/%0d",
                         c, baud_tick, xmit_pulse, os_cnt, exp_x, exp_os);
            end
        end
    endtask

    task automatic test_reset_mid_stretch();
        logic exp_tick;
        do_reset(13'd3, 3'd4);
        repeat (9) step();  // ticks at 1 and 5; edge 9 enters stretch
        n_checks++;
        if (baud_tick !== 1'b0 || os_cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL pre_reset_state: tick=%b os=%0d required 0/2", baud_tick, os_cnt);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (baud_tick !== 1'b0 || xmit_pulse !== 1'b0 || os_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset: tick=%b xmit=%b os=%0d required 0/0/0",
                     baud_tick, xmit_pulse, os_cnt);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (baud_tick !== 1'b0 || os_cnt !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: tick=%b os=%0d required 0/0", c, baud_tick, os_cnt);
            end
        end
        reset_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            exp_tick = (c == 1 || c == 5);
            n_checks++;
            if (baud_tick !== exp_tick) begin
                n_fail++;
                $display("FAIL post_reset_tick[c=%0d]: got %b required %b", c, baud_tick, exp_tick);
            end
            if (c == 1) begin
                n_checks++;
                if (os_cnt !== 4'd1 || xmit_pulse !== 1'b0) begin
                    n_fail++;
                    $display("FAIL post_reset_first: os=%0d xmit=%b required 1/0", os_cnt, xmit_pulse);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_integer_rate();
        test_half_fraction();
        test_min_divisor();
        test_freeze();
        test_mid_period_change();
        test_back_to_back();
        test_reset_mid_stretch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
